q_accum: RTL and testbench
==========================

// Module: q_accum
// PURPOSE
//   Sequential saturating accumulator for the team's sign-magnitude Q-format numbers (qadd/qmult/qdiv format).
//   Sits directly downstream of qadd/qmult and sums a job of LEN samples into one N-bit result.
//   Input and output use valid/ready handshakes; start launches a job, as for qdiv.
//   Format: bit N-1 = sign, bits N-2:0 = magnitude, low Q bits fractional.
// PARAMETERS
//   Q      23  fractional bits (affects interpretation only; arithmetic is format-agnostic)
//   N      32  word width incl. sign bit
//   CNT_W  8   width of sample-count input len
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      launch job; sampled only in IDLE
//   len        in   CNT_W  samples in job, latched with start; 0 allowed
//   in_valid   in   1      in_data valid
//   in_ready   out  1      block accepts in_data this cycle
//   in_data    in   N      sample, sign-magnitude Q
//   out_valid  out  1      out_data/ovf valid
//   out_ready  in   1      consumer takes result
//   out_data   out  N      accumulated sum, sign-magnitude Q
//   ovf        out  1      a saturation occurred during this job
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, acc=0, count=0, ovf=0, in_ready=0, out_valid=0, out_data=0.
//   FSM states IDLE, ACCUM, DONE; in_ready=1 iff state==ACCUM; out_valid=1 iff state==DONE.
//   IDLE:  start=1 -> latch len, acc<=+0, ovf<=0, count<=0; len==0 -> DONE, else ACCUM.
//   ACCUM: in_valid&in_ready accepts one sample: acc<=sat(acc+in_data), count<=count+1.
//          Accepting sample number len -> DONE next edge. in_valid=0 cycles: hold everything.
//   DONE:  out_data=acc, ovf held stable; out_valid&out_ready -> IDLE next edge.
//   start ignored in ACCUM/DONE; no job queueing. len sampled only at start.
//   Latency: out_valid rises the cycle after the last accepted sample (1 cycle after start if len=0).
//   Max throughput: one sample per clock; min job time len+1 cycles plus the output handshake.
//   Sign-magnitude add, magnitudes as N-bit unsigned (N-1 bits + carry):
//     same sign -> mag = |a|+|b|, sign kept; if mag >= 2^(N-1): mag = 2^(N-1)-1, ovf<=1 (sticky).
//     differing signs -> mag = larger-smaller, sign of larger magnitude operand.
//     result mag == 0 -> sign forced 0 (no -0 stored or emitted); input -0 treated as +0.
//   Saturated acc continues accumulating; later opposite-sign samples reduce it from the clipped value.
//   out_data and ovf are registered; no combinational path from in_data to out_data.
//   Reset mid-job: immediate abort to reset values; the partial sum is discarded.
// TESTING
//   T1 len=3: 0x00C00000(1.5), 0x01200000(2.25), 0x80600000(-0.75) -> out_data=0x01800000(3.0), ovf=0.
//   T2 len=2: 0x7FFFFFFF, 0x00000001 -> out_data=0x7FFFFFFF, ovf=1;
//      len=2: 0xFFFFFFFF, 0x80000001 -> out_data=0xFFFFFFFF, ovf=1.
//   T3 len=2: 0x00800000, 0x80800000 -> out_data=0x00000000 (never 0x80000000), ovf=0.
//   T4 len=0, start pulse -> out_valid=1 next cycle, out_data=0, ovf=0; in_ready stays 0.
//   T5 len=4 of 0x00800000, in_valid gapped; out_ready low 5 cycles -> in_ready=0 and start ignored
//      while out_valid=1; out_data=0x02000000 held; returns to IDLE one cycle after out_ready=1.
//   T6 rst_n=0 after 2 of 4 samples -> all outputs 0 asynchronously; next job len=1 of 0x00400000 -> 0x00400000.

Source files
------------

// File: rtl/q_accum.sv
// Saturating accumulator for sign-magnitude Q-format samples.
// Each job sums len samples from a valid/ready input stream and presents one registered result.
module q_accum #(
  parameter int Q     = 23,
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             ovf
);

  // The fractional width only changes how the bits are read, so the arithmetic never uses it.
  if (Q < 0 || Q > N - 1) begin : g_bad_q
    $error("q_accum: Q must lie in 0..N-1");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         sat;
  } add_t;

  state_t           state, state_d;
  logic [N-1:0]     acc, acc_d;
  logic [CNT_W-1:0] count, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  add_t             add_r;

  // Magnitudes are added as N-bit unsigned values, so bit N-1 of the sum is the carry.
  function automatic add_t sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-2:0] am, bm, mag;
    logic [N-1:0] mag_sum;
    logic         sgn;
    add_t         r;
    am      = a[N-2:0];
    bm      = b[N-2:0];
    mag     = '0;
    mag_sum = '0;
    sgn     = 1'b0;
    r.sat   = 1'b0;
    if (a[N-1] == b[N-1]) begin
      mag_sum = {1'b0, am} + {1'b0, bm};
      sgn     = a[N-1];
      if (mag_sum[N-1]) begin
        mag   = '1;
        r.sat = 1'b1;
      end else begin
        mag = mag_sum[N-2:0];
      end
    end else if (am >= bm) begin
      mag = am - bm;
      sgn = a[N-1];
    end else begin
      mag = bm - am;
      sgn = b[N-1];
    end
    // A zero magnitude is always stored as +0, which also absorbs any -0 input.
    if (mag == '0) sgn = 1'b0;
    r.sum = {sgn, mag};
    return r;
  endfunction

  assign add_r = sat_add(acc, in_data);

  // NOTE: every variable driven here gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    count_d = count;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state)
      IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d   = add_r.sum;
          ovf_d   = ovf_q | add_r.sat;
          count_d = count + CNT_W'(1);
          if (count_d == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      count <= count_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_q_accum.sv
// Bench for q_accum: table of jobs with a result scoreboard, plus hand-written
// sequences for empty jobs, output back-pressure and mid-job reset.
module tb_q_accum;

  localparam int N     = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_data;
  logic             ovf;

  q_accum #(.Q(23), .N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0]  len;
    logic [3:0][N-1:0] smp;
    logic [N-1:0]      data;
    logic              ovf;
  } vec_t;

  typedef struct {
    logic [N-1:0] data;
    logic         ovf;
  } exp_t;

  vec_t vt [8];
  exp_t sb [$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one job, pushing its expected result when it is launched.
  task automatic run_job(input vec_t v, input int gap);
    int n;
    start = 1'b1;
    len   = v.len;
    sb.push_back('{data: v.data, ovf: v.ovf});
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      in_valid = 1'b1;
      in_data  = v.smp[i];
      n = 0;
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      if (i < int'(v.len) - 1) repeat (gap) tick();
    end
    check("latency_out_valid", {31'b0, out_valid}, 32'd1);
    check("in_ready_low_in_done", {31'b0, in_ready}, 32'd0);
  endtask

  // Wait for a result, compare it against the scoreboard head, then complete the handshake.
  task automatic collect(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      check({name, "_timeout"}, {31'b0, out_valid}, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({name, "_unexpected"}, {31'b0, out_valid}, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({name, "_data"}, out_data, e.data);
    check({name, "_ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_idle_after"}, {30'b0, out_valid, in_ready}, 32'd0);
  endtask

  initial begin
    vec_t v;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vt[0] = '{len: 3, smp: {32'h0, 32'h80600000, 32'h01200000, 32'h00C00000}, data: 32'h01800000, ovf: 1'b0};
    vt[1] = '{len: 2, smp: {32'h0, 32'h0, 32'h00000001, 32'h7FFFFFFF}, data: 32'h7FFFFFFF, ovf: 1'b1};
    vt[2] = '{len: 2, smp: {32'h0, 32'h0, 32'h80000001, 32'hFFFFFFFF}, data: 32'hFFFFFFFF, ovf: 1'b1};
    vt[3] = '{len: 2, smp: {32'h0, 32'h0, 32'h80800000, 32'h00800000}, data: 32'h00000000, ovf: 1'b0};
    vt[4] = '{len: 3, smp: {32'h0, 32'h80000001, 32'h7FFFFFFF, 32'h7FFFFFFF}, data: 32'h7FFFFFFE, ovf: 1'b1};
    vt[5] = '{len: 2, smp: {32'h0, 32'h0, 32'h80000000, 32'h80000000}, data: 32'h00000000, ovf: 1'b0};
    vt[6] = '{len: 2, smp: {32'h0, 32'h0, 32'h80000008, 32'h00000005}, data: 32'h80000003, ovf: 1'b0};
    vt[7] = '{len: 1, smp: {32'h0, 32'h0, 32'h0, 32'h80000010}, data: 32'h80000010, ovf: 1'b0};

    #3;
    check("reset_outputs", {29'b0, in_ready, out_valid, ovf}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_job(vt[i], i % 2);
      collect($sformatf("vec%0d", i));
    end

    // Empty job: result appears one cycle after start without ever asking for input.
    v = '{len: 0, smp: '0, data: 32'h0, ovf: 1'b0};
    run_job(v, 0);
    collect("len0");

    // Gapped input, then a stalled consumer while start is pulsed and junk input is offered.
    v = '{len: 4, smp: {4{32'h00800000}}, data: 32'h02000000, ovf: 1'b0};
    run_job(v, 2);
    start    = 1'b1;
    len      = 8'd1;
    in_valid = 1'b1;
    in_data  = 32'h7FFFFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d_state", i), {30'b0, out_valid, in_ready}, 32'd2);
      check($sformatf("stall%0d_data", i), out_data, 32'h02000000);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    collect("stall");
    tick();
    check("no_queued_job", {30'b0, out_valid, in_ready}, 32'd0);

    // Reset in the middle of a saturating job discards it immediately.
    start = 1'b1;
    len   = 8'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h7FFFFFFF;
    repeat (2) tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_flags", {29'b0, in_ready, out_valid, ovf}, 32'd0);
    check("abort_out_data", out_data, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    v = '{len: 1, smp: {3'b0, 32'h00400000}, data: 32'h00400000, ovf: 1'b0};
    v.smp = {32'h0, 32'h0, 32'h0, 32'h00400000};
    run_job(v, 0);
    collect("after_reset");

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
